lmring_inject_arb: RTL
======================

// Module: lmring_inject_arb
// PURPOSE
//  Sequences the head of the LMRING. Arbitrates NREQ requesters (AXI-write, AXI-read, conf/reg host) onto one ring-head
//  packet stream, stamps a sequence number per packet, and bounds the number of outstanding reads.
//  Steers read returns from the ring tail back to the originating requester. Sits between the AXI slave and the first lmring stage.
// PARAMETERS
//  NREQ     3    number of requesters (index 0 = highest initial priority)
//  DATA_W   256  ring data width
//  SQ_W     16   sequence-number width
//  MAX_OUT  8    max outstanding reads (power of 2, >=2)
// PORTS
//  ACLK         in   1            clock
//  RSTN         in   1            async active-low reset
//  req_val      in   NREQ         requester i has a packet
//  req_last     in   NREQ         last beat of burst (releases grant lock)
//  req_rw       in   NREQ         0=read 1=write
//  req_ty       in   NREQ*3       packet type (4 = LMM range access)
//  req_col      in   NREQ*2       target column
//  req_a        in   NREQ*32      byte address
//  req_dm       in   NREQ*32      byte write mask
//  req_d        in   NREQ*DATA_W  write data
//  req_rdy      out  NREQ         packet of requester i accepted this cycle
//  head_nemp    out  1            ring-head packet valid
//  head_rw/ty/col/sq/a/dm/d out 1/3/2/SQ_W/32/32/DATA_W  ring-head packet fields (av driven 0 externally)
//  head_ful     in   1            ring head cannot accept
//  tail_nemp    in   1            ring-tail packet valid
//  tail_rw      in   1            tail packet rw
//  tail_d       in   DATA_W       tail packet data
//  tail_ful     out  1            backpressure to ring tail
//  rsp_val      out  NREQ         read data valid for requester i
//  rsp_d        out  DATA_W       read data (shared bus)
//  rsp_rdy      in   NREQ         requester i takes rsp_d
//  outstanding  out  log2(MAX_OUT)+1  reads in flight
// BEHAVIOUR
//  Reset: head_nemp=0, head fields 0, req_rdy=0, rsp_val=0, tail_ful=0, outstanding=0, sq counter=0,
//   rr pointer=0, lock=0, id FIFO empty. Reset mid-burst discards the lock and any held packet.
//  Output stage: single register. Load allowed when !head_nemp || !head_ful (load and drain same cycle OK).
//   Held packet stable while head_nemp && head_ful.
//  Eligibility: req_val[i] && !(req_rw[i]==0 && outstanding==MAX_OUT). Reads are masked when full; writes are never masked.
//  Arbitration FSM: IDLE -> pick first eligible index at/after rr pointer -> grant g; req_rdy[g]=1 on load (1-cycle latency to head).
//   If req_last[g]==0: enter LOCK(g); only g may load until a beat with req_last=1 loads, then return IDLE.
//   If g is ineligible in LOCK (read-full), hold the lock and issue nothing.
//   rr pointer <= g+1 mod NREQ when the lock releases (or single-beat grant).
//  Sequencing: head_sq <= sq counter on each load; counter +1 per load, wraps at 2^SQ_W.
//  Read tracking: each read load pushes g into an in-order id FIFO (depth MAX_OUT) and outstanding+1.
//  Return: a tail packet with tail_rw=0 pops the FIFO head id h and drives rsp_val[h]=1, rsp_d=tail_d until rsp_rdy[h].
//   tail_ful = rsp_val pending && !rsp_rdy[h]. Each pop does outstanding-1.
//   Issue and return in the same cycle: count unchanged.
//  Tail packets with tail_rw=1 (write echoes) are consumed silently and never stall.
//  Tail read with empty id FIFO is a protocol error: drop the packet, no count change (assertion in sim).
// TESTING
//  1 Reset, single write on req0 (a=0x1000, dm=0xFFFFFFFF), head_ful=0 -> head_nemp next cycle, sq=0, req_rdy[0] one pulse.
//  2 req0..2 all valid single-beat writes for 6 cycles -> grant order 0,1,2,0,1,2; sq 0..5.
//  3 req1 4-beat burst (last on beat 4) while req0 valid -> 4 consecutive req1 beats, then req0.
//  4 MAX_OUT=8 reads from req2, no returns -> 9th read stalls, outstanding=8; one return -> issue resumes next cycle.
//  5 Reads r0(req0), r1(req1) returned in order, rsp_rdy[0]=0 for 3 cycles -> rsp_val[0] held, tail_ful=1 3 cycles, then rsp_val[1].
//  6 head_ful=1 for 5 cycles with packet held -> head fields stable, no req_rdy; assert RSTN mid-burst -> all outputs at reset values.

Source files
------------

// File: rtl/lmring_inject_arb.sv
// lmring_inject_arb: ring-head sequencer. Arbitrates NREQ requesters onto one
// registered ring-head packet stream, stamps sequence numbers, bounds the
// number of reads in flight and steers read returns back to their requester.
module lmring_inject_arb #(
  parameter  int NREQ    = 3,
  parameter  int DATA_W  = 256,
  parameter  int SQ_W    = 16,
  parameter  int MAX_OUT = 8,
  localparam int OUT_W   = $clog2(MAX_OUT) + 1
) (
  input  logic                 ACLK,
  input  logic                 RSTN,
  input  logic [NREQ-1:0]      req_val,
  input  logic [NREQ-1:0]      req_last,
  input  logic [NREQ-1:0]      req_rw,
  input  logic [NREQ*3-1:0]    req_ty,
  input  logic [NREQ*2-1:0]    req_col,
  input  logic [NREQ*32-1:0]   req_a,
  input  logic [NREQ*32-1:0]   req_dm,
  input  logic [NREQ*DATA_W-1:0] req_d,
  output logic [NREQ-1:0]      req_rdy,
  output logic                 head_nemp,
  output logic                 head_rw,
  output logic [2:0]           head_ty,
  output logic [1:0]           head_col,
  output logic [SQ_W-1:0]      head_sq,
  output logic [31:0]          head_a,
  output logic [31:0]          head_dm,
  output logic [DATA_W-1:0]    head_d,
  input  logic                 head_ful,
  input  logic                 tail_nemp,
  input  logic                 tail_rw,
  input  logic [DATA_W-1:0]    tail_d,
  output logic                 tail_ful,
  output logic [NREQ-1:0]      rsp_val,
  output logic [DATA_W-1:0]    rsp_d,
  input  logic [NREQ-1:0]      rsp_rdy,
  output logic [OUT_W-1:0]     outstanding
);

  localparam int ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PTR_W = $clog2(MAX_OUT);

  typedef enum logic {ST_IDLE, ST_LOCK} state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     lock_id_q, lock_id_d;
  logic [ID_W-1:0]     rr_q, rr_d;
  logic [SQ_W-1:0]     sq_q, sq_d;

  logic                head_nemp_q, head_nemp_d;
  logic                head_rw_q, head_rw_d;
  logic [2:0]          head_ty_q, head_ty_d;
  logic [1:0]          head_col_q, head_col_d;
  logic [SQ_W-1:0]     head_sq_q, head_sq_d;
  logic [31:0]         head_a_q, head_a_d;
  logic [31:0]         head_dm_q, head_dm_d;
  logic [DATA_W-1:0]   head_d_q, head_d_d;

  logic [OUT_W-1:0]    out_q, out_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [ID_W-1:0]     fifo_q [MAX_OUT];

  logic                rsp_pend_q, rsp_pend_d;
  logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;

  logic [NREQ-1:0]     elig;
  logic                reads_full, load_ok, found, load;
  logic                sel_rw, sel_last, push, pop, tail_acc;
  logic [ID_W-1:0]     gnt_id;
  int                  gnt_int;

  // Reads are held back once MAX_OUT are in flight; writes always proceed.
  assign reads_full = (out_q == OUT_W'(MAX_OUT));

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign elig[gi]    = req_val[gi] && !(!req_rw[gi] && reads_full);
      assign req_rdy[gi] = RSTN && load && (gnt_id == ID_W'(gi));
      assign rsp_val[gi] = rsp_pend_q && (rsp_id_q == ID_W'(gi));
    end
  endgenerate

  // Grant selection: locked owner during a burst, else round-robin from rr_q.
  always_comb begin
    found  = 1'b0;
    gnt_id = '0;
    if (state_q == ST_LOCK) begin
      gnt_id = lock_id_q;
      found  = elig[lock_id_q];
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        if (!found && elig[(int'(rr_q) + k) % NREQ]) begin
          found  = 1'b1;
          gnt_id = ID_W'((int'(rr_q) + k) % NREQ);
        end
      end
    end
  end

  assign load_ok  = !head_nemp_q || !head_ful;
  assign load     = found && load_ok;
  assign gnt_int  = int'(gnt_id);
  assign sel_rw   = req_rw[gnt_id];
  assign sel_last = req_last[gnt_id];
  assign push     = load && !sel_rw;

  // A pending response blocks the tail only until its owner takes it.
  assign tail_ful = rsp_pend_q && !rsp_rdy[rsp_id_q];
  assign tail_acc = tail_nemp && !tail_ful;
  // A read return with nothing outstanding is dropped.
  assign pop      = tail_acc && !tail_rw && (out_q != '0);

  // Next-state for arbitration, head register, read tracking and response slot.
  always_comb begin
    state_d     = state_q;
    lock_id_d   = lock_id_q;
    rr_d        = rr_q;
    sq_d        = sq_q;
    head_nemp_d = head_nemp_q;
    head_rw_d   = head_rw_q;
    head_ty_d   = head_ty_q;
    head_col_d  = head_col_q;
    head_sq_d   = head_sq_q;
    head_a_d    = head_a_q;
    head_dm_d   = head_dm_q;
    head_d_d    = head_d_q;
    wr_ptr_d    = wr_ptr_q + PTR_W'(push);
    rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
    out_d       = out_q + OUT_W'(push) - OUT_W'(pop);
    rsp_pend_d  = rsp_pend_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;

    if (load_ok) begin
      head_nemp_d = load;
    end
    if (load) begin
      head_rw_d  = sel_rw;
      head_ty_d  = req_ty[gnt_int*3 +: 3];
      head_col_d = req_col[gnt_int*2 +: 2];
      head_sq_d  = sq_q;
      head_a_d   = req_a[gnt_int*32 +: 32];
      head_dm_d  = req_dm[gnt_int*32 +: 32];
      head_d_d   = req_d[gnt_int*DATA_W +: DATA_W];
      sq_d       = sq_q + 1'b1;
      if (sel_last) begin
        state_d = ST_IDLE;
        rr_d    = (gnt_id == ID_W'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
      end else begin
        state_d   = ST_LOCK;
        lock_id_d = gnt_id;
      end
    end

    if (rsp_pend_q && rsp_rdy[rsp_id_q]) begin
      rsp_pend_d = 1'b0;
    end
    if (pop) begin
      rsp_pend_d = 1'b1;
      rsp_id_d   = fifo_q[rd_ptr_q];
      rsp_data_d = tail_d;
    end
  end

  // State registers; reset drops any lock and any held head packet.
  always_ff @(posedge ACLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q     <= ST_IDLE;
      lock_id_q   <= '0;
      rr_q        <= '0;
      sq_q        <= '0;
      head_nemp_q <= 1'b0;
      head_rw_q   <= 1'b0;
      head_ty_q   <= '0;
      head_col_q  <= '0;
      head_sq_q   <= '0;
      head_a_q    <= '0;
      head_dm_q   <= '0;
      head_d_q    <= '0;
      out_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rsp_pend_q  <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      lock_id_q   <= lock_id_d;
      rr_q        <= rr_d;
      sq_q        <= sq_d;
      head_nemp_q <= head_nemp_d;
      head_rw_q   <= head_rw_d;
      head_ty_q   <= head_ty_d;
      head_col_q  <= head_col_d;
      head_sq_q   <= head_sq_d;
      head_a_q    <= head_a_d;
      head_dm_q   <= head_dm_d;
      head_d_q    <= head_d_d;
      out_q       <= out_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rsp_pend_q  <= rsp_pend_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // In-order id FIFO storage: requester index of each issued read.
  always_ff @(posedge ACLK) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= gnt_id;
    end
  end

  assign head_nemp   = head_nemp_q;
  assign head_rw     = head_rw_q;
  assign head_ty     = head_ty_q;
  assign head_col    = head_col_q;
  assign head_sq     = head_sq_q;
  assign head_a      = head_a_q;
  assign head_dm     = head_dm_q;
  assign head_d      = head_d_q;
  assign rsp_d       = rsp_data_q;
  assign outstanding = out_q;

  // A read return must always have a matching outstanding read.
  a_no_orphan_return: assert property (@(posedge ACLK) disable iff (!RSTN)
    (tail_nemp && !tail_ful && !tail_rw) |-> (out_q != '0));

endmodule
